dmac_read: RTL and testbench
============================

Name: dmac_read

Overview:
- DMA read-channel AXI master; the source-side counterpart of the DMA write engine.
- On a start pulse it issues one AXI read burst (AR channel) from the source address.
- It accepts R beats and pushes each beat's data into the shared DMA data FIFO, which the write engine drains.
- It reports completion and error status to the DMA controller.

Parameters:
- ADDR_WIDTH, 32, address width (matches `ADDR_WIDTH)
- DATA_WIDTH, 32, data width (matches `DATA_WIDTH)
- LEN_BITS, 8, burst length field width (AXI beats-1)
- SIZE_BITS, 3, burst size field width
- ID_BITS, 4, AXI ID width
- RD_ID, 0, constant ARID driven by this master; distinct from the write engine's ID (1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  1  start pulse; sampled only in IDLE
- src_addr_i  in  ADDR_WIDTH  burst start address
- len_i  in  LEN_BITS  beats-1
- size_i  in  SIZE_BITS  bytes per beat, log2
- burst_i  in  2  burst type
- fifo_full_i  in  1  data FIFO full
- read_push_o  out  1  FIFO write enable
- data_o  out  DATA_WIDTH  FIFO write data
- busy_o  out  1  high in any state other than IDLE
- m_arid  out  ID_BITS  AR ID
- m_araddr  out  ADDR_WIDTH  AR address
- m_arlen  out  LEN_BITS  AR length
- m_arsize  out  SIZE_BITS  AR size
- m_arburst  out  2  AR burst type
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rid  in  ID_BITS  R ID
- m_rdata  in  DATA_WIDTH  R data
- m_rresp  in  2  R response
- m_rlast  in  1  R last beat
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error status, valid while done_o is high

Behaviour:
- Single clock clk_i; asynchronous active-low reset rst_ni.
- Reset, including mid-burst: state=IDLE; all registers and outputs 0 (m_arvalid, m_rready, read_push_o, busy_o, done_o, err_o, data_o). A burst in flight is abandoned with no completion pulse.
- FSM states: IDLE, AR, R, DONE.
  - IDLE: on valid_i, latch src_addr_i, len_i, size_i, burst_i; clear beat counter and error flag; go to AR next cycle.
  - AR: m_arvalid=1; the latched fields drive the m_ar* outputs. m_arvalid holds until m_arvalid&&m_arready, then go to R. The m_ar* fields stay stable throughout AR.
  - R: m_rready = !fifo_full_i. Beat accepted when m_rvalid&&m_rready. On a beat: read_push_o=1 and data_o=m_rdata, both combinational in the same cycle; beat counter increments. Go to DONE on the handshake beat carrying m_rlast.
  - DONE: done_o=1 for exactly one cycle; err_o=sticky error flag; return to IDLE.
- valid_i is ignored outside IDLE. No queuing.
- Beat counter: LEN_BITS+1 bits, so a 256-beat burst does not wrap.
- The sticky error flag is set by any of these on an accepted beat:
  - m_rresp != 0 (SLVERR/DECERR)
  - m_rid != RD_ID
  - m_rlast on beat index != latched len (early last)
  - no m_rlast on beat index == latched len (missing last); the block keeps accepting beats until m_rlast
- Every beat with a bad response is still pushed into the FIFO; the controller discards the data on err_o.
- FIFO full: m_rready=0 and no push. No data is dropped or duplicated.
- fifo_full_i and m_rvalid deasserting in the same cycle: no transfer that cycle.
- AR latency: m_arvalid rises 1 cycle after valid_i. Minimum burst time: 1 (AR) + N beats + 1 (DONE) cycles.

Decomposition:
- FSM state enum, AXI response constants (OKAY=0, SLVERR=2, DECERR=3) and width defaults go in a shared dma_pkg, alongside the existing `define.sv` macros. The write engine migrates to the same package.
- No sub-module. The FSM, counter and error logic are flat.

Test Plan:
- Single beat: valid_i with src=0x1000, len=0, size=2, burst=INCR; ARREADY delayed 3 cycles -> m_arvalid held 3 cycles with m_araddr=0x1000 and m_arlen=0; one push of 0xDEADBEEF; done_o=1 with err_o=0.
- 4-beat burst, len=3, data 0x11..0x44 back-to-back -> 4 pushes in order, data_o matching each beat; done_o 1 cycle after the last beat.
- FIFO backpressure: fifo_full_i high for beats 2-3 of a 4-beat burst -> m_rready=0 while full; exactly 4 pushes in total; no loss and no duplication.
- Errors:
  - beat 1 has rresp=2 -> all beats pushed, err_o=1 at done
  - separately, m_rlast on beat 1 of len=3 -> err_o=1 and exit on that beat
- len=255 -> 256 pushes, no counter wrap, err_o=0.
- Reset asserted mid-R -> all outputs 0 immediately, state IDLE; the next valid_i starts a clean burst and completes with err_o=0.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA read and write engines: default field widths,
// AXI response and burst-type encodings, the engine FSM state encoding and a
// small helper that classifies an AXI response as an error.
// -----------------------------------------------------------------------------
package dma_pkg;

    // Default widths, kept equal to the project-wide ADDR/DATA width macros.
    localparam int unsigned DMA_ADDR_WIDTH = 32;
    localparam int unsigned DMA_DATA_WIDTH = 32;
    localparam int unsigned DMA_LEN_BITS   = 8;
    localparam int unsigned DMA_SIZE_BITS  = 3;
    localparam int unsigned DMA_ID_BITS    = 4;

    // AXI IDs owned by the two engines; they must never collide.
    localparam int unsigned DMA_RD_ID = 0;
    localparam int unsigned DMA_WR_ID = 1;

    // AXI response encodings.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    // AXI burst-type encodings.
    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    // Engine FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    // Anything other than OKAY is treated as a failed beat; the DMA never
    // issues exclusive accesses, so EXOKAY is unexpected as well.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage : dma_pkg

// File: rtl/dmac_read.sv
// -----------------------------------------------------------------------------
// dmac_read
// DMA read-channel AXI master. A start pulse in IDLE latches the burst
// descriptor and issues one AR request; every accepted R beat is pushed into
// the shared DMA data FIFO. At the end of the burst a one-cycle done_o pulse
// is raised together with a sticky error status.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   valid_i                start pulse (only honoured in IDLE)
//   src_addr_i, len_i,
//   size_i, burst_i        burst descriptor (len_i = beats-1)
//   fifo_full_i            data FIFO full; stalls the R channel
//   read_push_o, data_o    FIFO write enable / data (same cycle as the beat)
//   busy_o                 engine not idle
//   m_ar*                  AXI read-address channel (master side)
//   m_r*                   AXI read-data channel (master side)
//   done_o, err_o          completion pulse and its error status
// -----------------------------------------------------------------------------
module dmac_read
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int unsigned LEN_BITS   = DMA_LEN_BITS,
    parameter int unsigned SIZE_BITS  = DMA_SIZE_BITS,
    parameter int unsigned ID_BITS    = DMA_ID_BITS,
    parameter int unsigned RD_ID      = DMA_RD_ID
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [LEN_BITS-1:0]   len_i,
    input  logic [SIZE_BITS-1:0]  size_i,
    input  logic [1:0]            burst_i,
    input  logic                  fifo_full_i,
    output logic                  read_push_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic [ID_BITS-1:0]    m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [LEN_BITS-1:0]   m_arlen,
    output logic [SIZE_BITS-1:0]  m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_BITS-1:0]    m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [ID_BITS-1:0] RD_ID_C = ID_BITS'(RD_ID);

    // Registered state and descriptor.
    dma_state_e             state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [SIZE_BITS-1:0]   size_q;
    logic [1:0]             burst_q;
    // One extra bit so a 256-beat burst counts to 256 without wrapping.
    logic [LEN_BITS:0]      cnt_q;
    logic                   err_q;

    // Registered outputs.
    logic                   arvalid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_out_q;

    // Combinational beat decode.
    logic                   rready_s;
    logic                   beat_s;
    logic                   last_idx_s;
    logic                   beat_err_s;
    logic                   err_next_s;

    // R-channel handshake and per-beat error classification.
    always_comb begin
        rready_s   = 1'b0;
        beat_s     = 1'b0;
        last_idx_s = 1'b0;
        beat_err_s = 1'b0;
        if (state_q == ST_R) begin
            rready_s = !fifo_full_i;
        end else begin
            rready_s = 1'b0;
        end
        beat_s     = rready_s && m_rvalid;
        last_idx_s = (cnt_q == {1'b0, len_q});
        if (beat_s) begin
            // rlast must appear exactly on the beat whose index equals len;
            // a mismatch either way covers both early and missing last.
            beat_err_s = resp_is_err(m_rresp)
                       || (m_rid != RD_ID_C)
                       || (m_rlast != last_idx_s);
        end else begin
            beat_err_s = 1'b0;
        end
        err_next_s = err_q || beat_err_s;
    end

    // Main FSM: descriptor latch, AR handshake, beat counting, completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            len_q     <= {LEN_BITS{1'b0}};
            size_q    <= {SIZE_BITS{1'b0}};
            burst_q   <= 2'b00;
            cnt_q     <= {(LEN_BITS+1){1'b0}};
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        addr_q    <= src_addr_i;
                        len_q     <= len_i;
                        size_q    <= size_i;
                        burst_q   <= burst_i;
                        cnt_q     <= {(LEN_BITS+1){1'b0}};
                        err_q     <= 1'b0;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_AR;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_AR: begin
                    if (arvalid_q && m_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end else begin
                        state_q   <= ST_AR;
                    end
                end
                ST_R: begin
                    if (beat_s) begin
                        cnt_q <= cnt_q + {{LEN_BITS{1'b0}}, 1'b1};
                        err_q <= err_next_s;
                        if (m_rlast) begin
                            done_q    <= 1'b1;
                            err_out_q <= err_next_s;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q   <= ST_R;
                        end
                    end else begin
                        state_q <= ST_R;
                    end
                end
                ST_DONE: begin
                    done_q    <= 1'b0;
                    err_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    done_q    <= 1'b0;
                    err_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_arid      = RD_ID_C;
    assign m_araddr    = addr_q;
    assign m_arlen     = len_q;
    assign m_arsize    = size_q;
    assign m_arburst   = burst_q;
    assign m_arvalid   = arvalid_q;
    assign m_rready    = rready_s;
    assign read_push_o = beat_s;
    // Forced to zero between beats so idle FIFO data is deterministic.
    assign data_o      = beat_s ? m_rdata : {DATA_WIDTH{1'b0}};
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_out_q;

endmodule : dmac_read

// File: tb/tb_dmac_read.sv
// -----------------------------------------------------------------------------
// tb_dmac_read
// Directed self-checking bench for dmac_read. Inputs change 1 ns after the
// rising edge; FIFO pushes are captured on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmac_read;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] src_addr_i;
    logic [7:0]  len_i;
    logic [2:0]  size_i;
    logic [1:0]  burst_i;
    logic        fifo_full_i;
    logic        read_push_o;
    logic [31:0] data_o;
    logic        busy_o;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;
    logic        done_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] got[$];

    always #5 clk_i = ~clk_i;

    dmac_read dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .src_addr_i(src_addr_i), .len_i(len_i), .size_i(size_i),
        .burst_i(burst_i), .fifo_full_i(fifo_full_i),
        .read_push_o(read_push_o), .data_o(data_o), .busy_o(busy_o),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: capture any push on the falling edge, return 1 ns after rise.
    task automatic tick();
        @(negedge clk_i);
        if (read_push_o === 1'b1) got.push_back(data_o);
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [31:0] addr, input logic [7:0] len);
        valid_i    = 1'b1;
        src_addr_i = addr;
        len_i      = len;
        size_i     = 3'd2;
        burst_i    = 2'd1;
        tick();
        valid_i    = 1'b0;
        src_addr_i = 32'h0;
    endtask

    task automatic ar_hs();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last,
                        input logic [1:0] resp, input logic [3:0] id);
        m_rvalid = 1'b1;
        m_rdata  = d;
        m_rlast  = last;
        m_rresp  = resp;
        m_rid    = id;
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rresp  = 2'd0;
        m_rid    = 4'd0;
        m_rdata  = 32'h0;
    endtask

    initial begin
        int mism;
        rst_ni = 1'b0; valid_i = 1'b0; src_addr_i = 32'h0; len_i = 8'd0;
        size_i = 3'd0; burst_i = 2'd0; fifo_full_i = 1'b0; m_arready = 1'b0;
        m_rid = 4'd0; m_rdata = 32'h0; m_rresp = 2'd0; m_rlast = 1'b0;
        m_rvalid = 1'b0;
        #1;
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_rready", m_rready, 1'b0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();

        // Single beat with AR ready held off.
        start(32'h0000_1000, 8'd0);
        chk("t1_arvalid_c1", m_arvalid, 1'b1);
        chk("t1_araddr", m_araddr, 32'h0000_1000);
        chk("t1_arlen", m_arlen, 8'd0);
        chk("t1_arsize", m_arsize, 3'd2);
        chk("t1_arburst", m_arburst, 2'd1);
        chk("t1_arid", m_arid, 4'd0);
        chk("t1_busy", busy_o, 1'b1);
        tick();
        chk("t1_arvalid_c2", m_arvalid, 1'b1);
        chk("t1_araddr_c2", m_araddr, 32'h0000_1000);
        m_arready = 1'b1;
        #1;
        chk("t1_arvalid_c3", m_arvalid, 1'b1);
        tick();
        m_arready = 1'b0;
        chk("t1_arvalid_after", m_arvalid, 1'b0);
        chk("t1_rready", m_rready, 1'b1);
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1'b1;
        #1;
        chk("t1_push", read_push_o, 1'b1);
        chk("t1_data", data_o, 32'hDEAD_BEEF);
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        chk("t1_done", done_o, 1'b1);
        chk("t1_err", err_o, 1'b0);
        tick();
        chk("t1_done_pulse", done_o, 1'b0);
        chk("t1_idle_busy", busy_o, 1'b0);
        chk("t1_npush", got.size(), 1);
        chk("t1_pushed", got.size() > 0 ? got[0] : 32'hX, 32'hDEAD_BEEF);
        got.delete();

        // Four back-to-back beats.
        start(32'h0000_2000, 8'd3);
        ar_hs();
        beat(32'h11, 1'b0, 2'd0, 4'd0);
        beat(32'h22, 1'b0, 2'd0, 4'd0);
        beat(32'h33, 1'b0, 2'd0, 4'd0);
        beat(32'h44, 1'b1, 2'd0, 4'd0);
        chk("t2_done", done_o, 1'b1);
        chk("t2_err", err_o, 1'b0);
        chk("t2_npush", got.size(), 4);
        mism = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'(32'h11 * (i + 1))) mism++;
        chk("t2_order", mism, 0);
        tick();
        got.delete();

        // Backpressure on beats 2-3.
        start(32'h0000_3000, 8'd3);
        ar_hs();
        beat(32'hA0, 1'b0, 2'd0, 4'd0);
        beat(32'hA1, 1'b0, 2'd0, 4'd0);
        fifo_full_i = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'hA2;
        #1;
        chk("t3_rready_full", m_rready, 1'b0);
        chk("t3_push_full", read_push_o, 1'b0);
        tick(); tick();
        // Full and valid drop together: nothing moves.
        fifo_full_i = 1'b0; m_rvalid = 1'b0;
        #1;
        chk("t3_push_both_drop", read_push_o, 1'b0);
        tick();
        beat(32'hA2, 1'b0, 2'd0, 4'd0);
        fifo_full_i = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hA3; m_rlast = 1'b1;
        tick();
        chk("t3_no_done_full", done_o, 1'b0);
        fifo_full_i = 1'b0;
        beat(32'hA3, 1'b1, 2'd0, 4'd0);
        chk("t3_done", done_o, 1'b1);
        chk("t3_npush", got.size(), 4);
        mism = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'(32'hA0 + i)) mism++;
        chk("t3_order", mism, 0);
        tick();
        got.delete();

        // SLVERR on beat 1: all beats still pushed, error reported.
        start(32'h0000_4000, 8'd3);
        ar_hs();
        beat(32'hB0, 1'b0, 2'd0, 4'd0);
        beat(32'hB1, 1'b0, 2'd2, 4'd0);
        beat(32'hB2, 1'b0, 2'd0, 4'd0);
        beat(32'hB3, 1'b1, 2'd0, 4'd0);
        chk("t4_done", done_o, 1'b1);
        chk("t4_err", err_o, 1'b1);
        chk("t4_npush", got.size(), 4);
        tick();
        got.delete();

        // Early last on beat 1 of a 4-beat burst.
        start(32'h0000_5000, 8'd3);
        ar_hs();
        beat(32'hC0, 1'b0, 2'd0, 4'd0);
        beat(32'hC1, 1'b1, 2'd0, 4'd0);
        chk("t5_done", done_o, 1'b1);
        chk("t5_err", err_o, 1'b1);
        chk("t5_npush", got.size(), 2);
        tick();
        got.delete();

        // Missing last: len=0 but last comes on the second beat.
        start(32'h0000_5800, 8'd0);
        ar_hs();
        beat(32'hD0, 1'b0, 2'd0, 4'd0);
        chk("t6_no_done", done_o, 1'b0);
        beat(32'hD1, 1'b1, 2'd0, 4'd0);
        chk("t6_done", done_o, 1'b1);
        chk("t6_err", err_o, 1'b1);
        chk("t6_npush", got.size(), 2);
        tick();
        got.delete();

        // Wrong RID on an otherwise good single beat.
        start(32'h0000_5C00, 8'd0);
        ar_hs();
        beat(32'hE0, 1'b1, 2'd0, 4'd1);
        chk("t7_err", err_o, 1'b1);
        tick();
        got.delete();

        // 256-beat burst.
        start(32'h0001_0000, 8'd255);
        chk("t8_arlen", m_arlen, 8'd255);
        ar_hs();
        for (int i = 0; i < 256; i++)
            beat(32'hA500_0000 + 32'(i), (i == 255), 2'd0, 4'd0);
        chk("t8_done", done_o, 1'b1);
        chk("t8_err", err_o, 1'b0);
        chk("t8_npush", got.size(), 256);
        mism = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 32'hA500_0000 + 32'(i)) mism++;
        chk("t8_order", mism, 0);
        tick();
        got.delete();

        // Reset in the middle of the R phase.
        start(32'h0000_6000, 8'd3);
        ar_hs();
        beat(32'hF0, 1'b0, 2'd0, 4'd0);
        m_rvalid = 1'b1; m_rdata = 32'hF1;
        rst_ni = 1'b0;
        #1;
        chk("t9_rready", m_rready, 1'b0);
        chk("t9_push", read_push_o, 1'b0);
        chk("t9_data", data_o, 32'h0);
        chk("t9_busy", busy_o, 1'b0);
        chk("t9_done", done_o, 1'b0);
        chk("t9_err", err_o, 1'b0);
        tick();
        m_rvalid = 1'b0; m_rdata = 32'h0;
        rst_ni = 1'b1;
        tick();
        chk("t9_no_done_after", done_o, 1'b0);
        got.delete();
        start(32'h0000_7000, 8'd0);
        chk("t9_new_addr", m_araddr, 32'h0000_7000);
        ar_hs();
        beat(32'h1234_5678, 1'b1, 2'd0, 4'd0);
        chk("t9_new_done", done_o, 1'b1);
        chk("t9_new_err", err_o, 1'b0);
        chk("t9_new_npush", got.size(), 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmac_read
